// File: rtl/imem_loader.sv
// Boot-time program loader: writes a valid/ready word stream into instruction memory, then
// enables the CPU. Read-back checksum verification is built when IMEM_LOADER_VERIFY_EN is defined.
module imem_loader #(
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned MAX_WORDS = 512,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        load_start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic [31:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic        cpu_enable,
    output logic        busy,
    output logic        error,
    output logic [9:0]  word_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StVerify,
        StRun,
        StError
    } state_t;

    localparam logic [9:0] LastIdx = 10'(MAX_WORDS - 1);

    state_t      state;
    logic        reload_pending;
    logic [31:0] checksum;

`ifdef IMEM_LOADER_VERIFY_EN
    logic [9:0]  rd_idx;
    logic        rd_valid;
    logic [31:0] rd_sum;
`else
    logic        unused_rdata;
    assign unused_rdata = ^rdata_ext;
`endif

    function automatic logic [31:0] word_addr(input logic [9:0] idx);
        return BASE_ADDR + 32'(idx) * ADDR_STEP;
    endfunction

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state          <= StIdle;
            reload_pending <= 1'b0;
            checksum       <= '0;
            addr_ext       <= '0;
            wdata_ext      <= '0;
            wen_ext        <= 1'b0;
            ren_ext        <= 1'b0;
            cpu_enable     <= 1'b0;
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            error          <= 1'b0;
            word_count     <= '0;
`ifdef IMEM_LOADER_VERIFY_EN
            rd_idx         <= '0;
            rd_valid       <= 1'b0;
            rd_sum         <= '0;
`endif
        end else begin
            wen_ext <= 1'b0;
            ren_ext <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
            rd_valid <= ren_ext;
`endif
            unique case (state)
                StIdle: begin
                    // A reload requested from RUN/ERROR passes through here for one cycle.
                    if (load_start || reload_pending) begin
                        state          <= StLoad;
                        reload_pending <= 1'b0;
                        in_ready       <= 1'b1;
                        busy           <= 1'b1;
                        error          <= 1'b0;
                        word_count     <= '0;
                        checksum       <= '0;
                        addr_ext       <= BASE_ADDR;
                    end
                end
                StLoad: begin
                    if (in_valid && in_ready) begin
                        wen_ext    <= 1'b1;
                        addr_ext   <= word_addr(word_count);
                        wdata_ext  <= in_data;
                        word_count <= word_count + 10'd1;
                        checksum   <= checksum + in_data;
                        if (in_last) begin
                            in_ready <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
                            state    <= StVerify;
                            rd_idx   <= '0;
                            rd_sum   <= '0;
`else
                            state    <= StRun;
                            busy     <= 1'b0;
`endif
                        end else if (word_count == LastIdx) begin
                            // Capacity reached without end of program: the word is still written.
                            state    <= StError;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end
                    end
                end
`ifdef IMEM_LOADER_VERIFY_EN
                StVerify: begin
                    // First cycle carries the final write; reads start on the next one.
                    if (rd_idx != word_count) begin
                        ren_ext  <= 1'b1;
                        addr_ext <= word_addr(rd_idx);
                        rd_idx   <= rd_idx + 10'd1;
                    end
                    if (rd_valid) begin
                        rd_sum <= rd_sum + rdata_ext;
                        if (!ren_ext) begin
                            busy <= 1'b0;
                            if (32'(rd_sum + rdata_ext) == checksum) begin
                                state      <= StRun;
                                cpu_enable <= 1'b1;
                            end else begin
                                state <= StError;
                                error <= 1'b1;
                            end
                        end
                    end
                end
`endif
                StRun: begin
                    if (load_start) begin
                        state          <= StIdle;
                        reload_pending <= 1'b1;
                        cpu_enable     <= 1'b0;
                    end else begin
                        cpu_enable <= 1'b1;
                    end
                end
                StError: begin
                    if (load_start) begin
                        state          <= StIdle;
                        reload_pending <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader with a cycle-level behavioural model and
// a simple instruction-memory model (read-back corruption used when IMEM_LOADER_VERIFY_EN is set).
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int unsigned STEP = 4;
    localparam int unsigned MAXW = 8;
    localparam int unsigned BASE = 0;
    localparam int MI = 0, ML = 1, MV = 2, MR = 3, ME = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] in_data = '0;
    logic [31:0] rdata_ext = '0;
    logic        in_ready, wen_ext, ren_ext, cpu_enable, busy, error;
    logic [31:0] addr_ext, wdata_ext;
    logic [9:0]  word_count;

    int total = 0;
    int bad = 0;
    int nwrites = 0;
    int acc;
    bit corrupt = 1'b0;
    logic [31:0] mem [0:63];
    logic [31:0] words [$];

    // Behavioural model state
    int m = MI, n = 0, vt = 0;
    bit pend = 1'b0;
    logic e_wen = 0, e_ren = 0, e_cpu = 0, e_err = 0;
    logic [31:0] e_addr = '0, e_wdata = '0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_STEP(STEP), .MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .arst_n(arst_n), .load_start(load_start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .addr_ext(addr_ext),
        .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .cpu_enable(cpu_enable), .busy(busy), .error(error), .word_count(word_count)
    );

    // Instruction memory: synchronous write, read data one cycle after ren_ext.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        forever begin
            @(posedge clk);
            if (arst_n && wen_ext) begin
                mem[addr_ext[7:2]] <= wdata_ext;
                nwrites <= nwrites + 1;
            end
            if (ren_ext)
                rdata_ext <= mem[addr_ext[7:2]] ^
                             ((corrupt && addr_ext == BASE + 2 * STEP) ? 32'h0000_0100 : 32'h0);
        end
    end

    // Model: expected outputs for the next cycle from the rules of the loader.
    initial begin
        forever begin
            @(posedge clk or negedge arst_n);
            if (!arst_n) begin
                m = MI; n = 0; vt = 0; pend = 0;
                e_wen = 0; e_ren = 0; e_cpu = 0; e_err = 0; e_addr = '0; e_wdata = '0;
            end else begin
                e_wen = 0;
                e_ren = 0;
                case (m)
                    MI: if (load_start || pend) begin
                        m = ML; pend = 0; n = 0; e_err = 0; e_addr = BASE;
                    end
                    ML: if (in_valid) begin
                        e_wen = 1; e_addr = BASE + n * STEP; e_wdata = in_data; n++;
                        if (in_last) begin
`ifdef IMEM_LOADER_VERIFY_EN
                            m = MV; vt = 0;
`else
                            m = MR;
`endif
                        end else if (n == MAXW) begin
                            m = ME; e_err = 1;
                        end
                    end
                    MV: begin
                        if (vt < n) begin
                            e_ren = 1; e_addr = BASE + vt * STEP;
                        end
                        if (vt == n + 1) begin
                            if (corrupt && n > 2) begin m = ME; e_err = 1; end
                            else begin m = MR; e_cpu = 1; end
                        end
                        vt++;
                    end
                    MR: if (load_start) begin m = MI; pend = 1; e_cpu = 0; end
                        else e_cpu = 1;
                    ME: if (load_start) begin m = MI; pend = 1; end
                    default: m = MI;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            total++;
            if ({in_ready, wen_ext, ren_ext, cpu_enable, busy, error, word_count, addr_ext,
                 wdata_ext} !== {(m == ML), e_wen, e_ren, e_cpu, (m == ML || m == MV), e_err,
                 10'(n), e_addr, e_wdata}) begin
                bad++;
                $display("FAIL cycle@%0t got rdy=%b wen=%b ren=%b cpu=%b busy=%b err=%b wc=%0d addr=%h wd=%h | exp rdy=%b wen=%b ren=%b cpu=%b busy=%b err=%b wc=%0d addr=%h wd=%h",
                         $time, in_ready, wen_ext, ren_ext, cpu_enable, busy, error, word_count,
                         addr_ext, wdata_ext, (m == ML), e_wen, e_ren, e_cpu,
                         (m == ML || m == MV), e_err, n, e_addr, e_wdata);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start();
        load_start = 1'b1;
        step(1);
        load_start = 1'b0;
    endtask

    // Offers words[0..nw-1]; returns how many were accepted within a cycle budget.
    task automatic send(input int nw, input bit with_last, input int gap_pct, input bit pokes,
                        output int accepted);
        int budget;
        bit hs;
        budget = 60;
        accepted = 0;
        while (accepted < nw && budget > 0) begin
            in_valid   = ($urandom_range(99) >= gap_pct);
            in_data    = words[accepted];
            in_last    = with_last && (accepted == nw - 1);
            load_start = pokes && ($urandom_range(7) == 0);
            hs = in_valid && in_ready;
            step(1);
            if (hs) accepted++;
            budget--;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic fill(input int nw);
        words.delete();
        for (int i = 0; i < nw; i++) words.push_back($urandom);
    endtask

    initial begin
        int base_w;
        int len;
        step(3);
        arst_n = 1'b1;
        step(1);
        chk("reset_ready", {31'b0, in_ready}, 0);
        chk("reset_cpu", {31'b0, cpu_enable}, 0);
        chk("reset_addr", addr_ext, 0);
        chk("reset_wc", {22'b0, word_count}, 0);

        // Reset in the middle of a load.
        fill(4);
        start();
        send(2, 0, 0, 0, acc);
        chk("midload_busy", {31'b0, busy}, 1);
        #2 arst_n = 1'b0;
        #1;
        chk("arst_outs", {in_ready, wen_ext, ren_ext, cpu_enable, busy, error}, 0);
        chk("arst_addr", addr_ext, 0);
        chk("arst_wdata", wdata_ext, 0);
        chk("arst_wc", {22'b0, word_count}, 0);
        #3 arst_n = 1'b1;
        step(2);

        // Basic 4-word program.
        words = '{32'h20080005, 32'h20090003, 32'h01095020, 32'h00000000};
        start();
        send(4, 1, 0, 0, acc);
        chk("basic_acc", acc, 4);
        chk("basic_last_wen", {31'b0, wen_ext}, 1);
        chk("basic_last_addr", addr_ext, 12);
        chk("basic_wc", {22'b0, word_count}, 4);
`ifndef IMEM_LOADER_VERIFY_EN
        chk("basic_cpu_pre", {31'b0, cpu_enable}, 0);
        step(1);
        chk("basic_cpu", {31'b0, cpu_enable}, 1);
`else
        step(6);
        chk("basic_cpu", {31'b0, cpu_enable}, 1);
`endif
        chk("mem0", mem[0], 32'h20080005);
        chk("mem1", mem[1], 32'h20090003);
        chk("mem2", mem[2], 32'h01095020);
        chk("mem3", mem[3], 32'h00000000);

        // Reload from RUN.
        start();
        chk("reload_cpu_drop", {31'b0, cpu_enable}, 0);
        words = '{32'hCAFE0001, 32'hCAFE0002};
        send(2, 1, 0, 0, acc);
        chk("reload_addr", addr_ext, BASE + STEP);
        step(6);
        chk("reload_mem0", mem[0], 32'hCAFE0001);
        chk("reload_mem1", mem[1], 32'hCAFE0002);

        // Backpressure: 8 words with random gaps.
        fill(8);
        base_w = nwrites;
        start();
        send(8, 1, 50, 1, acc);
        step(12);
        chk("bp_acc", acc, 8);
        chk("bp_writes", nwrites - base_w, 8);
        for (int i = 0; i < 8; i++) chk("bp_mem", mem[i], words[i]);

        // Overflow: 9 words, no last.
        fill(9);
        base_w = nwrites;
        start();
        send(9, 0, 30, 0, acc);
        chk("ovf_acc", acc, 8);
        chk("ovf_writes", nwrites - base_w, 8);
        chk("ovf_err", {31'b0, error}, 1);
        chk("ovf_ready", {31'b0, in_ready}, 0);
        chk("ovf_cpu", {31'b0, cpu_enable}, 0);
        chk("ovf_wc", {22'b0, word_count}, 8);

        // Random programs, with ignored load_start pulses during LOAD.
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 8);
            fill(len);
            start();
            send(len, 1, 40, 1, acc);
            step(len + 4);
            chk("rnd_acc", acc, len);
            for (int i = 0; i < len; i++) chk("rnd_mem", mem[i], words[i]);
        end

`ifdef IMEM_LOADER_VERIFY_EN
        // Verify failure on corrupted readback of word 2.
        corrupt = 1'b1;
        fill(5);
        start();
        send(5, 1, 0, 0, acc);
        step(5);
        chk("ver_busy", {31'b0, busy}, 1);
        step(2);
        chk("ver_err", {31'b0, error}, 1);
        chk("ver_cpu", {31'b0, cpu_enable}, 0);
        corrupt = 1'b0;
        start();
        send(5, 1, 0, 0, acc);
        step(7);
        chk("ver_pass_cpu", {31'b0, cpu_enable}, 1);
`endif

        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
